vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with test-pattern source and a first-word-fall-through pixel stream input.
// Pipeline: counters (t) -> stage 1 terms + data_req_o (t+1) -> aligned sync/de/RGB outputs (t+2).
module vga_timing_gen #(
  parameter int HW        = 12,
  parameter int VW        = 11,
  parameter int CW        = 4,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int BAR_SHIFT = 6,
  parameter int CHK_SHIFT = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en_i,
  input  logic [HW-1:0]   h_total_i,
  input  logic [HW-1:0]   h_sync_end_i,
  input  logic [HW-1:0]   h_act_start_i,
  input  logic [HW-1:0]   h_act_end_i,
  input  logic [VW-1:0]   v_total_i,
  input  logic [VW-1:0]   v_sync_end_i,
  input  logic [VW-1:0]   v_act_start_i,
  input  logic [VW-1:0]   v_act_end_i,
  input  logic [1:0]      mode_i,
  input  logic [3*CW-1:0] solid_i,
  input  logic [3*CW-1:0] data_i,
  input  logic            data_valid_i,
  output logic            data_req_o,
  output logic [CW-1:0]   red_o,
  output logic [CW-1:0]   green_o,
  output logic [CW-1:0]   blue_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            de_o,
  output logic            frame_start_o,
  output logic            line_start_o,
  output logic            underflow_o,
  input  logic            clr_i
);

  typedef struct packed {
    logic [HW-1:0] h_total, h_sync_end, h_act_start, h_act_end;
    logic [VW-1:0] v_total, v_sync_end, v_act_start, v_act_end;
    logic [1:0]    mode;
  } timing_t;

  typedef struct packed {
    logic       hs, vs, act, fs, ls;
    logic [1:0] mode;
    logic [2:0] bar;
    logic       chk;
  } stage_t;

  localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};

  timing_t        cfg, sh;
  stage_t         s0, s1;
  logic [HW-1:0]  hcnt, x;
  logic [VW-1:0]  vcnt, y;
  logic           run, h_last, v_last;
  logic [3*CW-1:0] pix, rgb_q;

  assign run    = resetn & en_i;
  assign h_last = (hcnt == sh.h_total - H_ONE);
  assign v_last = (vcnt == sh.v_total - V_ONE);

  always_comb begin
    cfg.h_total     = h_total_i;
    cfg.h_sync_end  = h_sync_end_i;
    cfg.h_act_start = h_act_start_i;
    cfg.h_act_end   = h_act_end_i;
    cfg.v_total     = v_total_i;
    cfg.v_sync_end  = v_sync_end_i;
    cfg.v_act_start = v_act_start_i;
    cfg.v_act_end   = v_act_end_i;
    cfg.mode        = mode_i;
  end

  // An empty window (start >= end) falls out of the range test naturally.
  always_comb begin
    x       = hcnt - sh.h_act_start;
    y       = vcnt - sh.v_act_start;
    s0.hs   = hcnt < sh.h_sync_end;
    s0.vs   = vcnt < sh.v_sync_end;
    s0.act  = (hcnt >= sh.h_act_start) && (hcnt < sh.h_act_end) &&
              (vcnt >= sh.v_act_start) && (vcnt < sh.v_act_end);
    s0.fs   = (hcnt == '0) && (vcnt == '0);
    s0.ls   = (hcnt == '0);
    s0.mode = sh.mode;
    s0.bar  = 3'(x >> BAR_SHIFT);
    s0.chk  = 1'(x >> CHK_SHIFT) ^ 1'(y >> CHK_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
      sh   <= cfg;
      s1   <= '0;
    end else begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + V_ONE;
      end else begin
        hcnt <= hcnt + H_ONE;
      end
      if (h_last && v_last) sh <= cfg;
      s1 <= s0;
    end
  end

  assign data_req_o = s1.act && (s1.mode == 2'd0);

  always_comb begin
    pix = '0;
    if (s1.act) begin
      case (s1.mode)
        2'd0: pix = data_valid_i ? data_i : solid_i;
        2'd1: pix = {{CW{s1.bar[2]}}, {CW{s1.bar[1]}}, {CW{s1.bar[0]}}};
        2'd2: pix = solid_i;
        default: pix = {(3*CW){s1.chk}};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      frame_start_o <= 1'b0;
      line_start_o  <= 1'b0;
      rgb_q         <= '0;
      underflow_o   <= 1'b0;
    end else begin
      hsync_o       <= s1.hs ? HS_POL : ~HS_POL;
      vsync_o       <= s1.vs ? VS_POL : ~VS_POL;
      de_o          <= s1.act;
      frame_start_o <= s1.fs;
      line_start_o  <= s1.ls;
      rgb_q         <= pix;
      // A fresh underflow beats a simultaneous clear.
      underflow_o   <= (data_req_o && !data_valid_i) || (underflow_o && !clr_i);
    end
  end

  assign {blue_o, green_o, red_o} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a cycle model pushes predicted outputs, compared two cycles later.
module tb_vga_timing_gen;
  localparam int BAR = 3;
  localparam int CHKS = 2;

  logic        clk = 1'b0, resetn = 1'b0, en_i = 1'b0;
  logic [11:0] h_total_i, h_sync_end_i, h_act_start_i, h_act_end_i;
  logic [10:0] v_total_i, v_sync_end_i, v_act_start_i, v_act_end_i;
  logic [1:0]  mode_i;
  logic [11:0] solid_i, data_i;
  logic        data_valid_i, clr_i;
  logic        data_req_o, hsync_o, vsync_o, de_o, frame_start_o, line_start_o, underflow_o;
  logic [3:0]  red_o, green_o, blue_o;

  vga_timing_gen #(.BAR_SHIFT(BAR), .CHK_SHIFT(CHKS)) dut (
    .clk(clk), .resetn(resetn), .en_i(en_i),
    .h_total_i(h_total_i), .h_sync_end_i(h_sync_end_i),
    .h_act_start_i(h_act_start_i), .h_act_end_i(h_act_end_i),
    .v_total_i(v_total_i), .v_sync_end_i(v_sync_end_i),
    .v_act_start_i(v_act_start_i), .v_act_end_i(v_act_end_i),
    .mode_i(mode_i), .solid_i(solid_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_req_o(data_req_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .frame_start_o(frame_start_o), .line_start_o(line_start_o),
    .underflow_o(underflow_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    bit       hs, vs, act, fs, ls, c;
    bit [1:0] mode;
    bit [2:0] k;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Colour bars in {b,g,r} packing: k bit0 = red, bit1 = green, bit2 = blue.
  logic [11:0] bar_tab [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                               12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

  // Reference model, evaluated mid-cycle when all inputs for the next edge are stable.
  initial begin
    int          cyc = 0;
    bit          armed = 0, exp_req = 0, exp_uf = 0, sd_valid = 0, eof;
    logic [11:0] mh = 0, s_ht = 0, s_hse = 0, s_has = 0, s_hae = 0, sd_data = 0, sd_solid = 0, x, er;
    logic [10:0] mv = 0, s_vt = 0, s_vse = 0, s_vas = 0, s_vae = 0, y;
    bit   [1:0]  s_mode = 0;
    exp_t        e, r;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("data_req", data_req_o, exp_req);
        chk("underflow", underflow_o, exp_uf);
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          if (!e.act) er = 12'h000;
          else case (e.mode)
            2'd0: er = sd_valid ? sd_data : sd_solid;
            2'd1: er = bar_tab[e.k];
            2'd2: er = sd_solid;
            default: er = e.c ? 12'hFFF : 12'h000;
          endcase
          chk("hsync", hsync_o, e.hs ? 0 : 1);
          chk("vsync", vsync_o, e.vs ? 0 : 1);
          chk("de", de_o, e.act);
          chk("frame_start", frame_start_o, e.fs);
          chk("line_start", line_start_o, e.ls);
          chk("rgb", {blue_o, green_o, red_o}, er);
        end else begin
          chk("sb_due", (q.size() > 0) ? q[0].due : -1, cyc);
        end
      end
      sd_valid = data_valid_i;
      sd_data  = data_i;
      sd_solid = solid_i;
      if (!resetn || !en_i) begin
        q.delete();
        r = '{default: 0};
        r.due = cyc + 1; q.push_back(r);
        r.due = cyc + 2; q.push_back(r);
        mh = 0; mv = 0;
        s_ht = h_total_i; s_hse = h_sync_end_i; s_has = h_act_start_i; s_hae = h_act_end_i;
        s_vt = v_total_i; s_vse = v_sync_end_i; s_vas = v_act_start_i; s_vae = v_act_end_i;
        s_mode = mode_i;
        exp_req = 0; exp_uf = 0; armed = 1;
      end else begin
        x = mh - s_has;
        y = mv - s_vas;
        e.due  = cyc + 2;
        e.hs   = mh < s_hse;
        e.vs   = mv < s_vse;
        e.act  = (mh >= s_has) && (mh < s_hae) && (mv >= s_vas) && (mv < s_vae);
        e.fs   = (mh == 0) && (mv == 0);
        e.ls   = (mh == 0);
        e.mode = s_mode;
        e.k    = 3'((x >> BAR) & 12'd7);
        e.c    = x[CHKS] ^ y[CHKS];
        q.push_back(e);
        exp_uf  = (exp_req && !data_valid_i) ? 1'b1 : (clr_i ? 1'b0 : exp_uf);
        exp_req = e.act && (s_mode == 2'd0);
        eof = (mh == s_ht - 12'd1) && (mv == s_vt - 11'd1);
        if (mh == s_ht - 12'd1) begin
          mh = 0;
          mv = (mv == s_vt - 11'd1) ? 11'd0 : mv + 11'd1;
        end else mh = mh + 12'd1;
        if (eof) begin
          s_ht = h_total_i; s_hse = h_sync_end_i; s_has = h_act_start_i; s_hae = h_act_end_i;
          s_vt = v_total_i; s_vse = v_sync_end_i; s_vas = v_act_start_i; s_vae = v_act_end_i;
          s_mode = mode_i;
        end
      end
      cyc++;
    end
  end

  initial begin
    data_i = 12'h000;
    forever begin
      @(posedge clk); #1;
      data_i = 12'($urandom);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_cfg(input int ht, hse, has, hae, vt, vse, vas, vae, input bit [1:0] m);
    h_total_i = 12'(ht); h_sync_end_i = 12'(hse); h_act_start_i = 12'(has); h_act_end_i = 12'(hae);
    v_total_i = 11'(vt); v_sync_end_i = 11'(vse); v_act_start_i = 11'(vas); v_act_end_i = 11'(vae);
    mode_i = m;
  endtask

  task automatic reload();
    en_i = 1'b0; step(2); en_i = 1'b1;
  endtask

  task automatic wait_fs();
    int n = 0;
    step(1);
    while (!frame_start_o && n < 1000) begin step(1); n++; end
    if (!frame_start_o) chk("fs_timeout", frame_start_o, 1);
  endtask

  // Counts one output frame starting at the current frame_start_o cycle.
  task automatic measure(output int per, req, de, hl, vl, input int chg_at, input int chg_val);
    per = 0; req = 0; de = 0; hl = 0; vl = 0;
    do begin
      per++;
      req += int'(data_req_o); de += int'(de_o);
      hl += int'(!hsync_o);    vl += int'(!vsync_o);
      if (per == chg_at) h_total_i = 12'(chg_val);
      step(1);
    end while (!frame_start_o && per < 2000);
  endtask

  initial begin
    int per, req, de, hl, vl, n;
    set_cfg(10, 2, 3, 7, 6, 1, 2, 4, 2'd0);
    solid_i = 12'h5A3; data_valid_i = 1'b1; clr_i = 1'b0;
    step(3);
    resetn = 1'b1; en_i = 1'b1;

    // Baseline stream timing.
    wait_fs();
    for (int i = 0; i < 2; i++) begin
      measure(per, req, de, hl, vl, -1, 0);
      chk("period", per, 60); chk("req_cnt", req, 8); chk("de_cnt", de, 8);
      chk("hs_low", hl, 12);  chk("vs_low", vl, 10);
    end

    // Single missed pixel with a simultaneous clear: set wins, then clear.
    n = 0;
    while (!data_req_o && n < 200) begin step(1); n++; end
    chk("req_seen", data_req_o, 1);
    data_valid_i = 1'b0; clr_i = 1'b1;
    step(1);
    data_valid_i = 1'b1; clr_i = 1'b0;
    chk("uf_set_wins", underflow_o, 1);
    step(5);
    chk("uf_sticky", underflow_o, 1);
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    chk("uf_clr", underflow_o, 0);

    // Mid-frame h_total change only takes effect on the next frame.
    wait_fs();
    measure(per, req, de, hl, vl, 20, 12);
    chk("len_cur", per, 60);
    measure(per, req, de, hl, vl, -1, 0);
    chk("len_next", per, 72);

    // Colour bars, checker, solid.
    set_cfg(80, 8, 0, 64, 4, 1, 1, 3, 2'd1); reload(); step(330);
    set_cfg(40, 4, 2, 34, 12, 2, 1, 11, 2'd3); reload(); step(500);
    solid_i = 12'h3C9;
    set_cfg(20, 3, 4, 15, 5, 1, 1, 4, 2'd2); reload(); step(120);

    // Empty horizontal window.
    set_cfg(10, 2, 3, 3, 6, 1, 2, 4, 2'd0); reload();
    wait_fs();
    measure(per, req, de, hl, vl, -1, 0);
    chk("empty_period", per, 60); chk("empty_req", req, 0); chk("empty_de", de, 0);
    chk("empty_hs_low", hl, 12);  chk("empty_vs_low", vl, 10);

    // Reset pulse in the middle of a line.
    set_cfg(10, 2, 3, 7, 6, 1, 2, 4, 2'd0); reload();
    step(23);
    resetn = 1'b0; step(1);
    chk("rst_de", de_o, 0); chk("rst_hsync", hsync_o, 1); chk("rst_vsync", vsync_o, 1);
    chk("rst_rgb", {blue_o, green_o, red_o}, 0); chk("rst_req", data_req_o, 0);
    resetn = 1'b1; step(1);
    chk("fs_early", frame_start_o, 0);
    step(1);
    chk("fs_after_rst", frame_start_o, 1);
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
